// File: rtl/fft_pkg.sv
// Shared FFT constants and width/saturation helpers.
// Used by the butterfly datapath and its multiplier stage.
package fft_pkg;

  localparam int BF_LAT = 3;

  function automatic int part_w(input int n_w);
    return n_w / 2;
  endfunction

  function automatic int acc_w(input int n_w);
    return n_w + 2;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Butterfly stream interface: input vector handshake,
// result handshake and overflow flag.
interface butterfly_pipe_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] W;
  logic         inv;
  logic         scale;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         ovf;
  logic         ovf_clr;

  modport master (
    output in_valid, A, B, W, inv, scale,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, X, Y, ovf
  );

  modport slave (
    input  in_valid, A, B, W, inv, scale,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, X, Y, ovf
  );

endinterface

// File: rtl/cmul_pipe.sv
// Complex multiply B*W (or B*conj(W)): four partial
// products registered, combined on the output side.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int NP = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [NP-1:0] br,
  input  logic signed [NP-1:0] bi,
  input  logic signed [NP-1:0] wr,
  input  logic signed [NP-1:0] wi,
  input  logic                 inv,
  output logic signed [2*NP:0] pr,
  output logic signed [2*NP:0] pi
);

  localparam int MW = 2 * NP;
  localparam int PW = MW + 1;

  logic signed [MW-1:0] rr_q, rr_d;
  logic signed [MW-1:0] ii_q, ii_d;
  logic signed [MW-1:0] ri_q, ri_d;
  logic signed [MW-1:0] ir_q, ir_d;
  logic                 inv_q, inv_d;

  function automatic logic signed [MW-1:0] sx(
    input logic signed [NP-1:0] v
  );
    return {{NP{v[NP-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] ex(
    input logic signed [MW-1:0] v
  );
    return {v[MW-1], v};
  endfunction

  always_comb begin
    rr_d  = rr_q;
    ii_d  = ii_q;
    ri_d  = ri_q;
    ir_d  = ir_q;
    inv_d = inv_q;
    if (en) begin
      rr_d  = sx(br) * sx(wr);
      ii_d  = sx(bi) * sx(wi);
      ri_d  = sx(br) * sx(wi);
      ir_d  = sx(bi) * sx(wr);
      inv_d = inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      inv_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      ii_q  <= ii_d;
      ri_q  <= ri_d;
      ir_q  <= ir_d;
      inv_q <= inv_d;
    end
  end

  // conj(W) flips the sign of every Wi term
  always_comb begin
    if (inv_q) begin
      pr = ex(rr_q) + ex(ii_q);
      pi = ex(ir_q) - ex(ri_q);
    end else begin
      pr = ex(rr_q) - ex(ii_q);
      pi = ex(ir_q) + ex(ri_q);
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready,
// rounding, optional /2 scaling, saturation and sticky ovf.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int N   = 32,
  parameter int Q   = 8,
  parameter int SAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  butterfly_pipe_if.slave bus
);

  localparam int NP = part_w(N);
  localparam int AW = acc_w(N);
  localparam int PW = 2 * NP + 1;

  localparam logic signed [AW-1:0] MAXV =
    AW'(sat_max(NP));
  localparam logic signed [AW-1:0] MINV =
    AW'(sat_min(NP));

  logic adv;

  logic         v1_q, v1_d;
  logic [N-1:0] a1_q, a1_d;
  logic [N-1:0] b1_q, b1_d;
  logic [N-1:0] w1_q, w1_d;
  logic         inv1_q, inv1_d;
  logic         sc1_q, sc1_d;

  logic         v2_q, v2_d;
  logic [N-1:0] a2_q, a2_d;
  logic         sc2_q, sc2_d;

  logic         v3_q, v3_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] y_q, y_d;
  logic         ovf_q, ovf_d;

  logic signed [PW-1:0] pr, pi;
  logic signed [NP-1:0] ar, ai;
  logic signed [AW-1:0] xr, xi, yr, yi;
  logic                 lane_ovf;

  assign adv          = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    w1_d   = w1_q;
    inv1_d = inv1_q;
    sc1_d  = sc1_q;
    v2_d   = v2_q;
    a2_d   = a2_q;
    sc2_d  = sc2_q;
    if (adv) begin
      v1_d   = bus.in_valid;
      a1_d   = bus.A;
      b1_d   = bus.B;
      w1_d   = bus.W;
      inv1_d = bus.inv;
      sc1_d  = bus.scale;
      v2_d   = v1_q;
      a2_d   = a1_q;
      sc2_d  = sc1_q;
    end
  end

  cmul_pipe #(
    .NP (NP)
  ) u_cmul (
    .clk   (clk),
    .rst_n (reset),
    .en    (adv),
    .br    (b1_q[N-1:NP]),
    .bi    (b1_q[NP-1:0]),
    .wr    (w1_q[N-1:NP]),
    .wi    (w1_q[NP-1:0]),
    .inv   (inv1_q),
    .pr    (pr),
    .pi    (pi)
  );

  function automatic logic signed [AW-1:0] al(
    input logic signed [NP-1:0] v
  );
    logic signed [AW-1:0] t;
    t = {{(AW-NP){v[NP-1]}}, v};
    return t <<< Q;
  endfunction

  function automatic logic signed [AW-1:0] px(
    input logic signed [PW-1:0] v
  );
    return {v[PW-1], v};
  endfunction

  // round half up, then arithmetic shift by Q (+1 when scaling)
  function automatic logic signed [AW-1:0] rnd(
    input logic signed [AW-1:0] v,
    input logic                 sc
  );
    int                   s;
    logic signed [AW-1:0] t;
    s = Q + (sc ? 1 : 0);
    t = v;
    if (s > 0)
      t = v + (AW'(1) << (s - 1));
    return t >>> s;
  endfunction

  function automatic logic oor(
    input logic signed [AW-1:0] v
  );
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic [NP-1:0] clip(
    input logic signed [AW-1:0] v
  );
    if (SAT != 0 && v > MAXV)
      return MAXV[NP-1:0];
    if (SAT != 0 && v < MINV)
      return MINV[NP-1:0];
    return v[NP-1:0];
  endfunction

  assign ar = a2_q[N-1:NP];
  assign ai = a2_q[NP-1:0];

  always_comb begin
    xr = rnd(al(ar) + px(pr), sc2_q);
    xi = rnd(al(ai) + px(pi), sc2_q);
    yr = rnd(al(ar) - px(pr), sc2_q);
    yi = rnd(al(ai) - px(pi), sc2_q);
    lane_ovf = oor(xr) || oor(xi) ||
               oor(yr) || oor(yi);
  end

  always_comb begin
    v3_d  = v3_q;
    x_d   = x_q;
    y_d   = y_q;
    ovf_d = ovf_q && !bus.ovf_clr;
    if (adv) begin
      v3_d = v2_q;
      x_d  = {clip(xr), clip(xi)};
      y_d  = {clip(yr), clip(yi)};
      if (v2_q && lane_ovf)
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      w1_q   <= '0;
      inv1_q <= 1'b0;
      sc1_q  <= 1'b0;
      v2_q   <= 1'b0;
      a2_q   <= '0;
      sc2_q  <= 1'b0;
      v3_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      w1_q   <= w1_d;
      inv1_q <= inv1_d;
      sc1_q  <= sc1_d;
      v2_q   <= v2_d;
      a2_q   <= a2_d;
      sc2_q  <= sc2_d;
      v3_q   <= v3_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed vectors,
// expected X/Y queued at issue, popped by an output monitor.
module tb_butterfly_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  butterfly_pipe_if #(.N(32)) bus ();

  butterfly_pipe #(
    .N   (32),
    .Q   (8),
    .SAT (1)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   outs = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        outs++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got X=%h Y=%h expected none",
                   bus.X, bus.Y);
        end else begin
          e = q.pop_front();
          chk("X", bus.X, e.x);
          chk("Y", bus.Y, e.y);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] w,
                      input logic iv,
                      input logic sc,
                      input logic [31:0] ex,
                      input logic [31:0] ey,
                      input bit track);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.W = w;
    bus.inv = iv;
    bus.scale = sc;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    if (track)
      q.push_back('{ex, ey});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int o0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.W = '0;
    bus.inv = 1'b0;
    bus.scale = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_X", bus.X, 32'h0);
    chk("rst_Y", bus.Y, 32'h0);
    chk1("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    // unity twiddle, with latency probe
    send(32'h01000000, 32'h01000000, 32'h01000000,
         1'b0, 1'b0, 32'h02000000, 32'h0, 1'b1);
    idle();
    @(negedge clk);
    #1;
    chk1("lat_cycle2", bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("lat_cycle3", bus.out_valid, 1'b1);
    drain();
    chk1("ovf_unity", bus.ovf, 1'b0);

    // j twiddle, forward then conjugate back-to-back
    send(32'h01000000, 32'h01000000, 32'h00000100,
         1'b0, 1'b0, 32'h01000100, 32'h0100FF00, 1'b1);
    send(32'h01000000, 32'h01000000, 32'h00000100,
         1'b1, 1'b0, 32'h0100FF00, 32'h01000100, 1'b1);
    idle();
    drain();

    // half-LSB product rounds up
    send(32'h0, 32'h00010000, 32'h00800000,
         1'b0, 1'b0, 32'h00010000, 32'h0, 1'b1);
    idle();
    drain();

    // positive saturation, sticky flag, clear
    send(32'h7F000000, 32'h7F000000, 32'h01000000,
         1'b0, 1'b0, 32'h7FFF0000, 32'h0, 1'b1);
    idle();
    drain();
    chk1("ovf_set", bus.ovf, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk1("ovf_sticky", bus.ovf, 1'b1);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    #1;
    chk1("ovf_clr", bus.ovf, 1'b0);

    // same vector scaled stays in range
    send(32'h7F000000, 32'h7F000000, 32'h01000000,
         1'b0, 1'b1, 32'h7F000000, 32'h0, 1'b1);
    idle();
    drain();
    chk1("ovf_scaled", bus.ovf, 1'b0);

    // negative saturation
    send(32'h80000000, 32'h80000000, 32'h01000000,
         1'b0, 1'b0, 32'h80000000, 32'h0, 1'b1);
    idle();
    drain();
    chk1("ovf_neg", bus.ovf, 1'b1);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;

    // backpressure: 6 back-to-back, 5-cycle stall
    o0 = outs;
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send(k << 24, 32'h01000000, 32'h01000000,
               1'b0, 1'b0, (k + 1) << 24, (k - 1) << 24,
               1'b1);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk1("stall_in_ready", bus.in_ready, 1'b0);
        chk1("stall_out_valid", bus.out_valid, 1'b1);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", outs - o0, 6);

    // reset with vectors in flight
    send(32'h7F000000, 32'h7F000000, 32'h01000000,
         1'b0, 1'b0, 32'h7FFF0000, 32'h0, 1'b1);
    idle();
    drain();
    chk1("ovf_pre_rst", bus.ovf, 1'b1);
    send(32'h01000000, 32'h01000000, 32'h01000000,
         1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    send(32'h02000000, 32'h01000000, 32'h01000000,
         1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_X", bus.X, 32'h0);
    chk("mid_rst_Y", bus.Y, 32'h0);
    chk1("mid_rst_ovf", bus.ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk1("post_rst_quiet", bus.out_valid, 1'b0);
    o0 = outs;
    send(32'h01000000, 32'h01000000, 32'h00000100,
         1'b1, 1'b0, 32'h0100FF00, 32'h01000100, 1'b1);
    idle();
    drain();
    chk("post_rst_count", outs - o0, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
